// File: rtl/line_memory_pkg.sv
// Shared definitions for the line memory: bus widths, counter width
// and the controller FSM state encoding.
package line_memory_pkg;

    localparam int LINE_W   = 256;
    localparam int ADDR_W   = 32;
    localparam int OFFSET_W = 5;
    localparam int CNT_W    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

endpackage

// File: rtl/line_memory_if.sv
// Request/response bundle between cache controller and line memory.
// Ports: enable_i/write_i/addr_i/data_i (request), ack_o/data_o (response).
interface line_memory_if;
    import line_memory_pkg::*;

    logic              enable_i;
    logic              write_i;
    logic [ADDR_W-1:0] addr_i;
    logic [LINE_W-1:0] data_i;
    logic              ack_o;
    logic [LINE_W-1:0] data_o;

    modport master (
        output enable_i, write_i, addr_i, data_i,
        input  ack_o, data_o
    );

    modport slave (
        input  enable_i, write_i, addr_i, data_i,
        output ack_o, data_o
    );

endinterface

// File: rtl/line_memory_array.sv
// Line storage: single port, synchronous write, combinational read.
// Ports: clk_i, we_i, idx_i (line index), wdata_i, rdata_o. Not reset.
module line_memory_array
    import line_memory_pkg::*;
#(
    parameter int DEPTH = 512
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] idx_i,
    input  logic [LINE_W-1:0]        wdata_i,
    output logic [LINE_W-1:0]        rdata_o
);

    logic [LINE_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_mem[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = r_mem[idx_i];

endmodule

// File: rtl/line_memory.sv
// Fixed-latency line memory controller: accepts one request in IDLE,
// waits out the latency in BUSY and completes it in a single ACK cycle.
// Ports: clk_i, rst_i (async, active-low), bus (slave side of line_memory_if).
module line_memory
    import line_memory_pkg::*;
#(
    parameter int LATENCY = 10,
    parameter int DEPTH   = 512
) (
    input  logic         clk_i,
    input  logic         rst_i,
    line_memory_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH);
    // BUSY holds LATENCY-1 cycles; the count reaches LATENCY-1 on entering ACK.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LATENCY - 2);

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_write;
    logic [IDX_W-1:0]  r_idx;
    logic [LINE_W-1:0] r_wdata;
    logic [LINE_W-1:0] r_rdata;
    logic              w_accept;
    logic              w_done;
    logic              w_we;
    logic [LINE_W-1:0] w_mem_rd;
    logic              w_unused_addr;

    // Only the line index bits of the address matter.
    assign w_unused_addr = ^bus.addr_i;

    assign w_done = (r_state == BUSY) && (r_cnt == LAST);

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_we     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.enable_i) begin
                    w_accept = 1'b1;
                    w_next   = BUSY;
                end
            end
            BUSY: begin
                if (w_done) begin
                    w_next = ACK;
                end
            end
            ACK: begin
                w_we   = r_write;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_write <= bus.write_i;
                r_idx   <= bus.addr_i[OFFSET_W +: IDX_W];
                r_wdata <= bus.data_i;
                r_cnt   <= '0;
            end else if (r_state == BUSY) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // Capture read data on entry to ACK so data_o is valid there
            // and holds until the next read completes.
            if (w_done && !r_write) begin
                r_rdata <= w_mem_rd;
            end
        end
    end

    line_memory_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (w_we),
        .idx_i   (r_idx),
        .wdata_i (r_wdata),
        .rdata_o (w_mem_rd)
    );

    assign bus.ack_o  = (r_state == ACK);
    assign bus.data_o = r_rdata;

endmodule

// File: tb/tb_line_memory.sv
// Scoreboard bench for line_memory: expected acks queued at request time,
// checked by a negedge monitor.
module tb_line_memory;
    import line_memory_pkg::*;

    localparam int LAT = 10;

    typedef struct {
        int                cyc;
        logic [LINE_W-1:0] data;
    } sb_t;

    logic clk_i;
    logic rst_i;
    int   cyc;
    int   n_cmp;
    int   n_err;
    sb_t  sb[$];

    logic [LINE_W-1:0] mdl [512];
    logic [LINE_W-1:0] dout;

    line_memory_if bus ();

    line_memory #(
        .LATENCY (LAT),
        .DEPTH   (512)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [LINE_W-1:0] got,
                       input logic [LINE_W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    always @(negedge clk_i) begin : mon
        sb_t  e;
        logic ea;
        ea = (sb.size() > 0) && (sb[0].cyc == cyc);
        chk("ack", {255'd0, bus.ack_o}, {255'd0, ea});
        if (bus.ack_o && ea) begin
            e = sb.pop_front();
            chk("data_o", bus.data_o, e.data);
        end
    end

    task automatic preload(input int i, input logic [LINE_W-1:0] v);
        mdl[i] = v;
        dut.u_array.r_mem[i] = v;
    endtask

    function automatic logic [LINE_W-1:0] rnd_line();
        logic [LINE_W-1:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // Queue the expected completion of a request driven this cycle.
    task automatic expect_req(input logic w, input logic [31:0] a,
                              input logic [LINE_W-1:0] d, input int dly);
        sb_t e;
        if (w) mdl[a[13:5]] = d;
        else   dout = mdl[a[13:5]];
        e.cyc  = cyc + dly;
        e.data = dout;
        sb.push_back(e);
    endtask

    task automatic drive(input logic w, input logic [31:0] a,
                         input logic [LINE_W-1:0] d);
        bus.enable_i = 1'b1;
        bus.write_i  = w;
        bus.addr_i   = a;
        bus.data_i   = d;
    endtask

    task automatic idle_bus();
        bus.enable_i = 1'b0;
        bus.write_i  = 1'b0;
        bus.addr_i   = $urandom;
        bus.data_i   = rnd_line();
    endtask

    task automatic req(input logic w, input logic [31:0] a,
                       input logic [LINE_W-1:0] d);
        drive(w, a, d);
        expect_req(w, a, d, LAT);
        @(negedge clk_i);
        idle_bus();
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        if (sb.size() != 0) begin
            chk(tag, LINE_W'(sb.size()), '0);
            sb.delete();
        end
        @(negedge clk_i);
    endtask

    initial begin
        logic [LINE_W-1:0] d1;
        n_cmp = 0;
        n_err = 0;
        dout  = '0;
        rst_i = 1'b0;
        bus.enable_i = 1'b0;
        bus.write_i  = 1'b0;
        bus.addr_i   = '0;
        bus.data_i   = '0;
        for (int i = 0; i < 512; i++) mdl[i] = '0;

        preload(1, rnd_line());
        preload(2, rnd_line());
        preload(3, {32{8'hA5}});
        preload(4, rnd_line());
        preload(7, rnd_line());
        preload(8, 256'hFF);

        repeat (3) @(negedge clk_i);
        chk("rst_ack", {255'd0, bus.ack_o}, '0);
        chk("rst_data", bus.data_o, '0);
        chk("rst_state", LINE_W'(dut.r_state), LINE_W'(IDLE));
        chk("rst_cnt", LINE_W'(dut.r_cnt), '0);
        rst_i = 1'b1;
        @(negedge clk_i);

        // Basic read of preloaded line 3.
        req(1'b0, 32'h60, '0);
        wait_done("timeout_rd3");

        // Write then read back line 4.
        req(1'b1, 32'h80, 256'h1234);
        wait_done("timeout_wr4");
        req(1'b0, 32'h80, '0);
        wait_done("timeout_rd4");

        // Held enable: back-to-back reads every LAT+1 cycles.
        drive(1'b0, 32'h60, '0);
        expect_req(1'b0, 32'h60, '0, LAT);
        expect_req(1'b0, 32'h60, '0, 2 * LAT + 1);
        expect_req(1'b0, 32'h60, '0, 3 * LAT + 2);
        repeat (30) @(negedge clk_i);
        idle_bus();
        wait_done("timeout_hold");

        // Inputs thrashed while a write to line 1 is in flight.
        d1 = rnd_line();
        drive(1'b1, 32'h20, d1);
        expect_req(1'b1, 32'h20, d1, LAT);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk_i);
            bus.enable_i = 1'($urandom);
            bus.write_i  = 1'($urandom);
            bus.addr_i   = ($urandom & ~32'h3FE0) | 32'h40;
            bus.data_i   = rnd_line();
        end
        @(negedge clk_i);
        idle_bus();
        wait_done("timeout_thrash");
        req(1'b0, 32'h20, '0);
        wait_done("timeout_rd1");
        req(1'b0, 32'h40, '0);
        wait_done("timeout_rd2");

        // Reset mid-write to line 7: aborted, no ack, line kept.
        drive(1'b1, 32'hE0, rnd_line());
        @(negedge clk_i);
        idle_bus();
        repeat (4) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("abort_state", LINE_W'(dut.r_state), LINE_W'(IDLE));
        chk("abort_cnt", LINE_W'(dut.r_cnt), '0);
        chk("abort_data", bus.data_o, '0);
        rst_i = 1'b1;
        dout  = '0;
        repeat (LAT + 3) @(negedge clk_i);
        req(1'b0, 32'hE0, '0);
        wait_done("timeout_rd7");

        // Write ack leaves the last read data on data_o.
        req(1'b0, 32'h100, '0);
        wait_done("timeout_rd8");
        req(1'b1, 32'h80, rnd_line());
        wait_done("timeout_wr4b");
        req(1'b0, 32'h80, '0);
        wait_done("timeout_rd4b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/line_memory.md
LINE_MEMORY -- requirements
Module: line_memory

Interface
REQ-001 Parameter LATENCY, default 10, SHALL set the number of cycles from request acceptance to ack; legal range 2..255.
REQ-002 Parameter DEPTH, default 512, SHALL set the number of 256-bit lines stored; power of two.
REQ-003 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  SHALL be the reset, asynchronous and active-low (0 = reset asserted).
REQ-005 enable_i  input  1  SHALL be the request valid from the cache controller.
REQ-006 write_i  input  1  SHALL select the request type: 1 = line write, 0 = line read; sampled with enable_i.
REQ-007 addr_i  input  32  SHALL be the byte address; line index = addr_i[5+log2(DEPTH)-1:5]; other bits ignored.
REQ-008 data_i  input  256  SHALL be the write line; sampled at acceptance.
REQ-009 ack_o  output  1  SHALL be the one-cycle completion pulse.
REQ-010 data_o  output  256  SHALL be the read line, valid in the ack cycle.

Function
REQ-011 FSM states SHALL be IDLE, BUSY and ACK.
REQ-012 In IDLE with enable_i=1, the block SHALL accept the request: latch write_i, line index and data_i, clear the counter, and enter BUSY.
REQ-013 In BUSY the counter SHALL increment each cycle; at count = LATENCY-1 the FSM SHALL enter ACK; ack_o SHALL be high exactly LATENCY cycles after the acceptance edge.
REQ-014 In the ACK cycle a write SHALL update the addressed line, and a read SHALL drive that line on data_o, using latched values only.
REQ-015 ACK SHALL return to IDLE unconditionally after one cycle; ack_o SHALL be high in ACK only.
REQ-016 enable_i, write_i, addr_i and data_i SHALL be ignored in BUSY and ACK; input changes mid-request SHALL have no effect.
REQ-017 A new request SHALL be accepted no earlier than the first IDLE cycle after ACK; held enable_i SHALL start a second request there, giving a minimum period of LATENCY+1 cycles.
REQ-018 data_o SHALL hold its last read value until the next read ack; a write ack SHALL leave data_o unchanged.
REQ-019 A read of a line written in the immediately preceding transaction SHALL return the new data.
REQ-020 The counter SHALL be 8 bits wide and SHALL never wrap within a request.

Reset
REQ-021 While rst_i=0: state = IDLE, counter = 0, ack_o = 0, data_o = 0, and latched request registers = 0.
REQ-022 Reset during BUSY or ACK SHALL abort the request with no line update and no ack.
REQ-023 Storage contents SHALL NOT be reset; the bench initialises them by memory preload.

Structure
REQ-024 A shared package SHALL hold LINE_W=256, ADDR_W=32, OFFSET_W=5 and the FSM state enum.
REQ-025 The storage array SHALL be a sub-module, line_memory_array: single-port, synchronous write, combinational read, with DEPTH as its parameter.
REQ-026 Control (FSM, counter, latches) SHALL remain in line_memory.

Verification
REQ-027 Reset then preload line 3 = 256'hA5..A5; read addr 32'h60 at cycle 0 -> ack_o high at cycle 10 only, data_o = A5..A5.
REQ-028 Write addr 32'h80 with data 256'h1234 -> ack at +10; following read of 32'h80 -> data_o = 256'h1234, ack at +10 after its acceptance.
REQ-029 Hold enable_i=1 for 30 cycles (reads) -> acks at cycles 10 and 21; no more than one ack per 11 cycles.
REQ-030 Change addr_i and data_i every cycle during BUSY of a write to 32'h20 -> only line 1 is updated, with the data from the acceptance cycle.
REQ-031 Assert rst_i=0 at cycle 5 of a write to line 7 -> no ack; line 7 unchanged; state = IDLE; next request completes normally.
REQ-032 Write ack after a read of 256'hFF -> data_o stays 256'hFF.
